// File: rtl/auto_freq_gen_pkg.sv
// auto_freq_gen_pkg: shared state encodings, widths and constants for the square-wave generator
package auto_freq_gen_pkg;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONV   = 3'd1,
      S_SCALE  = 3'd2,
      S_DIVIDE = 3'd3,
      S_RUN    = 3'd4
   } state_t;
   localparam int F_MHZ_W  = 24;
   localparam int PERIOD_W = 30;
   localparam logic [PERIOD_W-1:0] DVND_1E9 = 30'd1_000_000_000;
   function automatic logic [F_MHZ_W-1:0] mul10(input logic [F_MHZ_W-1:0] a);
      return (a << 3) + (a << 1);
   endfunction
endpackage

// File: rtl/auto_freq_gen_if.sv
// auto_freq_gen_if: control/status bundle of the generator
//   master drives start, stop, bcd3..bcd0, decimal_point; slave drives
//   sq_out, running, ready, done_tick, err, period_us
interface auto_freq_gen_if;
   import auto_freq_gen_pkg::*;
   logic                start;
   logic                stop;
   logic [3:0]          bcd3;
   logic [3:0]          bcd2;
   logic [3:0]          bcd1;
   logic [3:0]          bcd0;
   logic [1:0]          decimal_point;
   logic                sq_out;
   logic                running;
   logic                ready;
   logic                done_tick;
   logic                err;
   logic [PERIOD_W-1:0] period_us;
   modport master (output start, stop, bcd3, bcd2, bcd1, bcd0, decimal_point,
                   input sq_out, running, ready, done_tick, err, period_us);
   modport slave  (input start, stop, bcd3, bcd2, bcd1, bcd0, decimal_point,
                   output sq_out, running, ready, done_tick, err, period_us);
endinterface

// File: rtl/auto_freq_gen_bcd_to_mhz.sv
// auto_freq_gen_bcd_to_mhz: BCD digits + decimal point -> frequency in mHz
//   clk, reset_n (async, active low), start, digits {bcd3..bcd0}, dp in;
//   done_tick (one cycle, f_mhz valid), bad (digit > 9 seen), f_mhz out
//   Macro AUTO_FREQ_GEN_BCD_CHECK_EN enables the digit range check.
module auto_freq_gen_bcd_to_mhz
   import auto_freq_gen_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [15:0]        digits,
   input  logic [1:0]         dp,
   output logic               done_tick,
   output logic               bad,
   output logic [F_MHZ_W-1:0] f_mhz
);
   state_t st_q, st_d;
   logic [15:0] dig_q, dig_d;
   logic [1:0] dp_q, dp_d, n_q, n_d;
   logic [F_MHZ_W-1:0] acc_q, acc_d;
   logic done_q, done_d, bad_q, bad_d, bad_digit;
`ifdef AUTO_FREQ_GEN_BCD_CHECK_EN
   assign bad_digit = dig_q[15:12] > 4'd9;
`else
   assign bad_digit = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q   <= S_IDLE;
         dig_q  <= '0;
         dp_q   <= '0;
         n_q    <= '0;
         acc_q  <= '0;
         done_q <= 1'b0;
         bad_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         dig_q  <= dig_d;
         dp_q   <= dp_d;
         n_q    <= n_d;
         acc_q  <= acc_d;
         done_q <= done_d;
         bad_q  <= bad_d;
      end
   end
   // digits are consumed MSD first by shifting the latched word left
   always_comb begin
      st_d   = st_q;
      dig_d  = dig_q;
      dp_d   = dp_q;
      n_d    = n_q;
      acc_d  = acc_q;
      done_d = 1'b0;
      bad_d  = bad_q;
      if (start) begin
         st_d  = S_CONV;
         dig_d = digits;
         dp_d  = dp;
         n_d   = 2'd0;
         acc_d = '0;
         bad_d = 1'b0;
      end else if (st_q == S_CONV && bad_digit) begin
         st_d   = S_IDLE;
         done_d = 1'b1;
         bad_d  = 1'b1;
      end else if (st_q == S_CONV) begin
         acc_d = mul10(acc_q) + F_MHZ_W'(dig_q[15:12]);
         dig_d = {dig_q[11:0], 4'h0};
         n_d   = n_q + 2'd1;
         if (n_q == 2'd3) begin
            st_d   = (dp_q == 2'd3) ? S_IDLE : S_SCALE;
            done_d = dp_q == 2'd3;
         end
      end else if (st_q == S_SCALE) begin
         acc_d = mul10(acc_q);
         n_d   = n_q + 2'd1;
         if (n_q == 2'd2 - dp_q) begin
            st_d   = S_IDLE;
            done_d = 1'b1;
         end
      end
   end
   assign done_tick = done_q;
   assign bad       = bad_q;
   assign f_mhz     = acc_q;
endmodule

// File: rtl/div.sv
// div: sequential restoring divider, one quotient bit per clock
//   clk, reset (async, active high), start, dvsr, dvnd in;
//   ready (idle), done_tick (one cycle, result valid), quo, rmd out
module div #(
   parameter int W    = 30,
   parameter int CBIT = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dvsr,
   input  logic [W-1:0] dvnd,
   output logic         ready,
   output logic         done_tick,
   output logic [W-1:0] quo,
   output logic [W-1:0] rmd
);
   typedef enum logic [1:0] {D_IDLE, D_OP, D_DONE} dstate_t;
   dstate_t st_q, st_d;
   logic [W-1:0] rem_q, rem_d, quo_q, quo_d, d_q, d_d;
   logic [CBIT-1:0] n_q, n_d;
   logic [W:0] trial, diff;
   logic ge;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q  <= D_IDLE;
         rem_q <= '0;
         quo_q <= '0;
         d_q   <= '0;
         n_q   <= '0;
      end else begin
         st_q  <= st_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         d_q   <= d_d;
         n_q   <= n_d;
      end
   end
   always_comb begin
      st_d  = st_q;
      rem_d = rem_q;
      quo_d = quo_q;
      d_d   = d_q;
      n_d   = n_q;
      trial = {rem_q, quo_q[W-1]};
      diff  = trial - {1'b0, d_q};
      ge    = trial >= {1'b0, d_q};
      case (st_q)
         D_IDLE: if (start) begin
            st_d  = D_OP;
            rem_d = '0;
            quo_d = dvnd;
            d_d   = dvsr;
            n_d   = '0;
         end
         D_OP: begin
            rem_d = ge ? diff[W-1:0] : trial[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            n_d   = n_q + 1'b1;
            st_d  = (n_q == CBIT'(W-1)) ? D_DONE : D_OP;
         end
         default: st_d = D_IDLE;
      endcase
   end
   assign ready     = st_q == D_IDLE;
   assign done_tick = st_q == D_DONE;
   assign quo       = quo_q;
   assign rmd       = rem_q;
endmodule

// File: rtl/auto_freq_gen.sv
// auto_freq_gen: BCD frequency in, square wave out (period = 1e9 / f_mHz microseconds)
//   clk, reset_n (async, active low), bus (auto_freq_gen_if.slave)
//   Parameters: CLK_MHZ clocks per microsecond, TICK_W prescaler width.
//   Macro AUTO_FREQ_GEN_BCD_CHECK_EN rejects digits > 9 with err.
module auto_freq_gen
   import auto_freq_gen_pkg::*;
#(
   parameter int CLK_MHZ = 100,
   parameter int TICK_W  = 7
) (
   input logic            clk,
   input logic            reset_n,
   auto_freq_gen_if.slave bus
);
   localparam logic [TICK_W-1:0] PRE_MAX = TICK_W'(CLK_MHZ - 1);
   state_t state_q, state_d;
   logic [TICK_W-1:0] pre_q, pre_d;
   logic [PERIOD_W-1:0] us_q, us_d, period_q, period_d, quo, unused_rmd;
   logic [F_MHZ_W-1:0] f_mhz;
   logic err_q, err_d, done_q, done_d, issued_q, issued_d;
   logic div_start, div_ready, div_done, conv_done, conv_bad, tick, reject;
   auto_freq_gen_bcd_to_mhz u_conv (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (bus.start),
      .digits    ({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}),
      .dp        (bus.decimal_point),
      .done_tick (conv_done),
      .bad       (conv_bad),
      .f_mhz     (f_mhz)
   );
   div #(.W(PERIOD_W), .CBIT(5)) u_div (
      .clk       (clk),
      .reset     (~reset_n),
      .start     (div_start),
      .dvsr      ({{(PERIOD_W-F_MHZ_W){1'b0}}, f_mhz}),
      .dvnd      (DVND_1E9),
      .ready     (div_ready),
      .done_tick (div_done),
      .quo       (quo),
      .rmd       (unused_rmd)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         pre_q    <= '0;
         us_q     <= '0;
         period_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         issued_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         us_q     <= us_d;
         period_q <= period_d;
         err_q    <= err_d;
         done_q   <= done_d;
         issued_q <= issued_d;
      end
   end
   assign tick   = pre_q == PRE_MAX;
   assign reject = conv_bad || f_mhz == '0;
   // issued_q marks that this run's division was started; a done_tick from an
   // aborted earlier division arrives with issued_q low and is ignored
   always_comb begin
      state_d   = state_q;
      pre_d     = '0;
      us_d      = '0;
      period_d  = period_q;
      err_d     = err_q;
      done_d    = 1'b0;
      issued_d  = issued_q;
      div_start = 1'b0;
      if (bus.start) begin
         state_d  = S_CONV;
         err_d    = 1'b0;
         issued_d = 1'b0;
      end else begin
         case (state_q)
            S_CONV: if (conv_done) begin
               state_d = reject ? S_IDLE : S_DIVIDE;
               err_d   = reject;
            end
            S_DIVIDE: if (!issued_q && div_ready) begin
               div_start = 1'b1;
               issued_d  = 1'b1;
            end else if (issued_q && div_done) begin
               period_d = quo;
               done_d   = 1'b1;
               state_d  = S_RUN;
            end
            S_RUN: begin
               state_d = bus.stop ? S_IDLE : S_RUN;
               pre_d   = tick ? '0 : pre_q + 1'b1;
               us_d    = tick ? (us_q == period_q - 1'b1 ? '0 : us_q + 1'b1) : us_q;
            end
            default: ;
         endcase
      end
   end
   // high for the first floor(period/2) microseconds, so odd periods lengthen the low phase
   assign bus.sq_out    = state_q == S_RUN && us_q < (period_q >> 1);
   assign bus.running   = state_q == S_RUN;
   assign bus.ready     = state_q == S_IDLE;
   assign bus.done_tick = done_q;
   assign bus.err       = err_q;
   assign bus.period_us = period_q;
endmodule

// File: doc/auto_freq_gen.md
Name: auto_freq_gen

Overview:
- Square-wave generator that takes a 4-digit BCD frequency with a decimal-point position.
- Computes the period in microseconds, then drives sq_out continuously at that frequency.
- Inverse of the low-frequency counter chain: BCD→binary mHz, then 1e9/f_mHz gives period_us, then a µs-tick output stage.
- Sits beside the frequency counter in the same design, so one board can generate and measure the same signal.

Parameters:
- CLK_MHZ, 100, clock cycles per microsecond; sets the µs tick prescaler.
- TICK_W, 7, width of the prescaler counter; must hold CLK_MHZ-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: latch the inputs and (re)start generation.
- stop  in  1  one-cycle pulse: halt output.
- bcd3, bcd2, bcd1, bcd0  in  4 each  BCD digits, bcd3 is the MSD.
- decimal_point  in  2  number of digits right of the decimal point (0..3).
- sq_out  out  1  generated square wave.
- running  out  1  high while in the run state.
- ready  out  1  high in idle.
- done_tick  out  1  one-cycle pulse when generation begins.
- err  out  1  sticky error flag; cleared by the next start.
- period_us  out  30  computed period; holds its last value.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to idle.
  - sq_out=0, running=0, ready=1, done_tick=0, err=0, period_us=0.
  - All counters cleared.
  - Any in-flight conversion or division is abandoned.
- States: idle, conv, scale, divide, run.
- idle:
  - start=1 latches the digits and decimal_point, clears err, then goes to conv.
- conv, 4 cycles:
  - acc = acc*10 + digit, bcd3 first.
  - acc width is 24 bits.
- scale, 3-decimal_point cycles (0 cycles when decimal_point=3):
  - acc = acc*10 per cycle.
  - Result is f_mHz, max 9,999,000.
- Zero check on leaving scale:
  - If f_mHz == 0: set err, return to idle, sq_out stays 0.
- divide:
  - Pulse div start for 1 cycle, with dvnd=1,000,000,000 and dvsr={6'b0,f_mHz}.
  - Wait for div done_tick.
  - Load period_us = quotient; the remainder is discarded (truncation).
  - Go to run and pulse done_tick in the same cycle.
- run:
  - The µs prescaler counts 0..CLK_MHZ-1 and produces one tick per µs.
  - sq_out = 1 for floor(period_us/2) ticks, then 0 for period_us - floor(period_us/2) ticks, repeating.
  - Odd periods put the extra µs in the low phase.
  - sq_out rises on the first clk of run.
- stop:
  - In run: sq_out=0 on the next clk, state goes to idle, period_us is held.
  - stop in any other state is ignored.
- start during conv, scale, divide or run:
  - Aborts the current operation, latches the new inputs and goes to conv.
  - sq_out=0 from the next clk.
  - If the divider is busy, its result is ignored by sequencing; it is never restarted mid-operation.
- Simultaneous start and stop: start wins.
- Minimum period: 100 µs at 9999 Hz. Maximum period: 1e9 µs at 0.001 Hz.

Optional Feature:
- Macro: AUTO_FREQ_GEN_BCD_CHECK_EN.
- Defined: in conv, any digit > 9 sets err and returns to idle without dividing. sq_out stays 0.
- Undefined: no digit check. Digits > 9 are weighted arithmetically (e.g. 4'hA contributes 10 at its position).

Decomposition:
- Shared package/header holds:
  - State encodings: idle=3'd0, conv=3'd1, scale=3'd2, divide=3'd3, run=3'd4.
  - DVND_1E9 = 30'd1_000_000_000.
  - F_MHZ_W = 24 and PERIOD_W = 30.
- Natural sub-module: bcd_to_mhz, covering the conv and scale sequencer with start/done_tick handshake.
- Division uses the team's existing div (W=30, CBIT=5), with reset driven by ~reset_n.

Test Plan:
- CLK_MHZ=10; digits 1,0,0,0, dp=0; start → period_us=1000; sq_out high 5000 clk, low 5000 clk, repeating; done_tick pulses once.
- CLK_MHZ=1; digits 0,0,0,7, dp=0 → period_us=142857; high 71428 clk, low 71429 clk.
- Digits 2,5,0,0, dp=3 (2.5 Hz) → f_mHz=2500, period_us=400000.
- All digits 0 → err=1 after conv+scale, state back to idle, sq_out=0, period_us unchanged.
- In run, pulse stop → sq_out=0 the next clk, ready=1. Then start with 9,9,9,9, dp=0 → period_us=100.
- reset_n low during divide → all outputs at reset values immediately. A later start completes normally.
- With AUTO_FREQ_GEN_BCD_CHECK_EN, bcd1=4'hA → err=1, no div start. Without it → f_mHz=(1*1000+0*100+10*10+0)*1000.
